iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring integer divider for the ARM datapath; the inverse of the ALU's MUL/UMULL/SMULL operations. Implements UDIV/SDIV.
- Sits beside the ALU. The controller issues a start pulse, holds the datapath stalled while busy is high, and writes quotient and remainder back on done.
- ARM semantics apply:
  - divide-by-zero returns quotient 0;
  - INT_MIN / -1 returns INT_MIN;
  - the remainder takes the sign of the dividend.

---
 rtl/div_pkg.sv | 15 +
 rtl/iter_divider_if.sv | 24 ++
 rtl/div_step.sv | 30 +++
 rtl/iter_divider.sv | 115 +++++++++++
 tb/tb_iter_divider.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the controller and the divider.
interface iter_divider_if #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the divisor, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nx,
  output logic [WIDTH-1:0] q_nx
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    trial = r_sh - {1'b0, d};
    // A set top bit means the subtraction borrowed, so keep the shifted remainder.
    if (!trial[WIDTH]) begin
      r_nx = trial[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nx = r_sh[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for UDIV/SDIV with ARM result semantics.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  iter_divider_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned MSB   = WIDTH - 1;

  div_state_t       state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sgn_r;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_nx, q_nx;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;
  logic             busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;

  // Magnitudes of the captured operands; INT_MIN maps to 2^(WIDTH-1) as unsigned.
  assign a_abs_c = (sgn_r && a_r[MSB]) ? -a_r : a_r;
  assign b_abs_c = (sgn_r && b_r[MSB]) ? -b_r : b_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r    (r_q),
    .q    (q_q),
    .d    (d_q),
    .r_nx (r_nx),
    .q_nx (q_nx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sgn_r  <= 1'b0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            sgn_r  <= bus.is_signed;
            dbz_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          if (b_r == '0) begin
            quot_r <= '0;
            rem_r  <= a_r;
            dbz_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            neg_q <= sgn_r & (a_r[MSB] ^ b_r[MSB]);
            neg_r <= sgn_r & a_r[MSB];
            r_q   <= '0;
            q_q   <= a_abs_c;
            d_q   <= b_abs_c;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= ITER;
          end
        end
        ITER: begin
          r_q <= r_nx;
          q_q <= q_nx;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          quot_r <= neg_q ? -q_q : q_q;
          rem_r  <= neg_r ? -r_q : r_q;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver queues expected results, monitor checks on done.
module tb_iter_divider;

  localparam int unsigned W        = 32;
  localparam int          LAT_NORM = W + 2;
  localparam int          LAT_DBZ  = 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   done_cnt;
  logic prev_done;
  exp_t sb[$];

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the oldest expectation whenever the divider reports done.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      done_cnt++;
      check("no_double_done", W'(prev_done), W'(0));
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
        check("latency", W'(cyc - e.acc), W'(e.lat));
        check("busy_with_done", W'(bus.busy), W'(1));
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic do_div(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    wait_idle();
    bus.a         = ta;
    bus.b         = tb_v;
    bus.is_signed = ts;
    bus.start     = 1'b1;
    sb.push_back('{q: eq, r: er, dbz: ed, lat: (ed ? LAT_DBZ : LAT_NORM), acc: cyc + 1});
    @(negedge clk);
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = ~ts;
    check("busy_after_start", W'(bus.busy), W'(1));
  endtask

  initial begin
    int n;
    int snap;
    n_tests       = 0;
    n_fail        = 0;
    done_cnt      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_quotient", bus.quotient, W'(0));
    check("rst_remainder", bus.remainder, W'(0));
    check("rst_dbz", W'(bus.div_by_zero), W'(0));
    rst_n = 1'b1;

    do_div(32'd100,        32'd7,          1'b0, 32'd14,       32'd2,          1'b0);
    do_div(32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE,   1'b0);
    do_div(32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2, 32'd2,          1'b0);
    do_div(32'h12345678,   32'd0,          1'b0, 32'd0,        32'h12345678,   1'b1);
    do_div(32'h12345678,   32'd0,          1'b1, 32'd0,        32'h12345678,   1'b1);
    do_div(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,          1'b0);
    do_div(32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,          1'b0);
    do_div(32'd5,          32'd9,          1'b0, 32'd0,        32'd5,          1'b0);
    do_div(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF,   1'b0);
    do_div(32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000,   1'b0);

    // start held high: operand changes mid-operation must not matter; next accept is the IDLE cycle after done
    wait_idle();
    bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0; bus.start = 1'b1;
    sb.push_back('{q: 32'd14, r: 32'd2, dbz: 1'b0, lat: LAT_NORM, acc: cyc + 1});
    repeat (5) @(negedge clk);
    bus.a = 32'd200; bus.b = 32'd3;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_start_done_seen", W'(bus.done), W'(1));
    @(negedge clk);
    check("idle_after_done", W'(bus.busy), W'(0));
    sb.push_back('{q: 32'd66, r: 32'd2, dbz: 1'b0, lat: LAT_NORM, acc: cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_second_accept", W'(bus.busy), W'(1));

    // asynchronous reset in the middle of ITER
    wait_idle();
    bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_busy", W'(bus.busy), W'(0));
    check("async_rst_done", W'(bus.done), W'(0));
    check("async_rst_quotient", bus.quotient, W'(0));
    check("async_rst_remainder", bus.remainder, W'(0));
    check("async_rst_dbz", W'(bus.div_by_zero), W'(0));
    snap = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", W'(done_cnt), W'(snap));
    do_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);

    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
